// File: rtl/psum_xchg_pkg.sv
// Shared constants and width helper for the partial-sum exchange block.
package psum_xchg_pkg;

    localparam logic MODE_ALL  = 1'b0;
    localparam logic MODE_PAIR = 1'b1;

    // Result width that holds a sum of num_core signed bw_sum operands without overflow.
    function automatic int unsigned bw_out(input int unsigned bw_sum, input int unsigned num_core);
        return bw_sum + $clog2(num_core);
    endfunction

endpackage

// File: rtl/psum_xchg_fifo.sv
// Per-core input FIFO: registered pointers/occupancy, combinational head read.
module psum_xchg_fifo #(
    parameter int unsigned BW_SUM = 24,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BW_SUM-1:0] wdata,
    output logic [BW_SUM-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [BW_SUM-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/psum_ring_xchg.sv
// Partial-sum exchange: buffers one signed sum per core, then reduces across all cores or pairs.
// Optional macro PSUM_XCHG_CNT_EN adds a 16-bit count of completed output handshakes.
module psum_ring_xchg
    import psum_xchg_pkg::*;
#(
    parameter  int unsigned NUM_CORE = 4,
    parameter  int unsigned BW_SUM   = 24,
    parameter  int unsigned DEPTH    = 4,
    localparam int unsigned BW_OUT   = bw_out(BW_SUM, NUM_CORE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic [NUM_CORE-1:0]        in_req,
    output logic [NUM_CORE-1:0]        in_ack,
    input  logic [NUM_CORE*BW_SUM-1:0] in_sum,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [NUM_CORE*BW_OUT-1:0] out_sum
`ifdef PSUM_XCHG_CNT_EN
    ,
    output logic [15:0]                xfer_cnt
`endif
);

    logic [NUM_CORE-1:0] full, empty, push;
    logic [BW_SUM-1:0]   head [NUM_CORE];
    logic                run_q;
    logic                pop;

    logic                       out_req_q, out_req_d;
    logic [NUM_CORE*BW_OUT-1:0] out_sum_q, out_sum_d;
    logic signed [BW_OUT-1:0]   ext [NUM_CORE];
    logic signed [BW_OUT-1:0]   total;

    // in_ack is held low through reset and for the cycle it is released in.
    assign in_ack = ~full & {NUM_CORE{run_q}};
    assign push   = in_req & in_ack;
    assign pop    = ~|empty & (~out_req_q | out_ack);

    for (genvar g = 0; g < NUM_CORE; g++) begin : g_fifo
        psum_xchg_fifo #(
            .BW_SUM (BW_SUM),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop),
            .wdata (in_sum[g*BW_SUM +: BW_SUM]),
            .rdata (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    always_comb begin
        total     = '0;
        out_sum_d = out_sum_q;
        out_req_d = out_req_q;
        for (int i = 0; i < int'(NUM_CORE); i++) begin
            ext[i] = BW_OUT'($signed(head[i]));
            total  = total + ext[i];
        end
        if (pop) begin
            out_req_d = 1'b1;
            for (int i = 0; i < int'(NUM_CORE); i++) begin
                out_sum_d[i*BW_OUT +: BW_OUT] = (mode == MODE_PAIR) ? ext[i] + ext[i ^ 1] : total;
            end
        end else if (out_ack) begin
            out_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q     <= 1'b0;
            out_req_q <= 1'b0;
            out_sum_q <= '0;
        end else begin
            run_q     <= 1'b1;
            out_req_q <= out_req_d;
            out_sum_q <= out_sum_d;
        end
    end

    assign out_req = out_req_q;
    assign out_sum = out_sum_q;

`ifdef PSUM_XCHG_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (out_req_q && out_ack) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: doc/psum_ring_xchg.md
PSUM_RING_XCHG -- requirements
Module: psum_ring_xchg

Interface
- REQ-001: The module SHALL have parameter NUM_CORE, default 4: the number of cores exchanging partial sums; legal values are even and at least 2.
- REQ-002: The module SHALL have parameter BW_SUM, default 24: the width of one core's signed partial sum.
- REQ-003: The module SHALL have parameter DEPTH, default 4: the entries per input FIFO; legal values are a power of 2 and at least 2.
- REQ-004: Port clk  input  1  is the single clock; all logic SHALL be on its rising edge.
- REQ-005: Port reset  input  1  SHALL be a synchronous, active-low reset (0 = reset).
- REQ-006: Port mode  input  1  selects reduction: 0 = ALL (sum across every core), 1 = PAIR (sum of core i and core i^1).
- REQ-007: Port in_req  input  NUM_CORE  carries one per-core valid bit.
- REQ-008: Port in_ack  output  NUM_CORE  carries one per-core ready bit.
- REQ-009: Port in_sum  input  NUM_CORE*BW_SUM  holds the per-core signed sums; core i occupies slice [i*BW_SUM +: BW_SUM].
- REQ-010: Port out_req  output  1  SHALL be the registered result-valid signal.
- REQ-011: Port out_ack  input  1  is the consumer accept.
- REQ-012: Port out_sum  output  NUM_CORE*BW_OUT  holds one result per core, where BW_OUT = BW_SUM + clog2(NUM_CORE).

Function
- REQ-013: An input transfer on core i SHALL occur in any cycle where in_req[i] and in_ack[i] are both 1; the sample is written into FIFO i at that clock edge.
- REQ-014: in_ack[i] SHALL equal "FIFO i not full" and SHALL NOT depend combinationally on out_ack; there is no bypass, so a full FIFO keeps in_ack low even in a pop cycle.
- REQ-015: A pop event SHALL occur in a cycle where all FIFOs are non-empty and (out_req == 0 or out_ack == 1).
  - On a pop, the head of every FIFO is removed simultaneously.
  - On the same edge, the out_sum register is loaded and out_req is set to 1.
- REQ-016: When out_ack == 1 and no pop occurs, out_req SHALL clear on that edge.
- REQ-017: While out_req == 1 and out_ack == 0, out_sum and out_req SHALL hold stable.
- REQ-018: Arithmetic SHALL sign-extend every input to BW_OUT before summing, so no overflow is possible.
  - ALL mode: every out_sum slot equals the total of all heads.
  - PAIR mode: slot i equals head[i] + head[i^1].
- REQ-019: mode SHALL be sampled only in the pop cycle; changing it at other times has no effect on results already registered.
- REQ-020: Latency: if the last missing sample is transferred in cycle t and the output is free, out_req SHALL be 1 from cycle t+2.
- REQ-021: Throughput SHALL be one result per cycle while all FIFOs are non-empty and out_ack is held at 1.
- REQ-022: A simultaneous push and pop on the same FIFO SHALL leave its occupancy unchanged.
- REQ-023: FIFO read and write pointers SHALL wrap from DEPTH-1 to 0.

Reset
- REQ-024: While reset == 0, the following SHALL all be 0 at the clock edge: FIFO pointers and occupancy counts, out_req, out_sum, in_ack, and the counter of REQ-026.
- REQ-025: A reset asserted mid-operation SHALL discard all buffered samples and any pending result; in_ack SHALL rise in the first cycle after reset returns to 1.

Configuration
- REQ-026: With macro PSUM_XCHG_CNT_EN defined, the module SHALL add port xfer_cnt  output  16  , counting completed output handshakes (out_req & out_ack) and wrapping 65535 -> 0.
- REQ-027: Without PSUM_XCHG_CNT_EN, the xfer_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
- REQ-028: Package psum_xchg_pkg SHALL hold the mode constants MODE_ALL = 0 and MODE_PAIR = 1, plus the BW_OUT width-derivation function.
- REQ-029: A single sub-module psum_xchg_fifo (parameters BW_SUM, DEPTH; outputs full and empty) SHALL be instantiated NUM_CORE times.

Verification
- REQ-030: Reset case: NUM_CORE=4, ALL mode, one sample each of 5, -3, 7, 1 in cycle 0 -> out_req=1 in cycle 2 and every slot = 10.
- REQ-031: Sign-extension case: PAIR mode, inputs 100, -100, -8388608, -1 -> slots 0 and 1 = 0, slots 2 and 3 = -8388609 with no overflow.
- REQ-032: Backpressure case: hold out_ack=0 and push DEPTH+1 samples on core 0 only -> in_ack[0]=0 after DEPTH transfers and no out_req, since the other FIFOs are empty.
- REQ-033: Staggered-input case: cores 0-2 send at cycle 0 and core 3 at cycle 5 -> out_req first 1 at cycle 7.
- REQ-034: Streaming case: out_ack held at 1 with continuous input -> one result per cycle, and xfer_cnt (macro on) increments every cycle.
- REQ-035: Mid-stream reset case: assert reset with 3 samples buffered and out_req=1 -> all outputs 0 the next cycle, and no stale result after reset is released.
